// File: rtl/pwm_duty_ramp.sv
// Duty-cycle slew limiter for the PWM counter stage: accepts a target/step
// request and moves dutyval toward it by at most one step per PWM period.
module pwm_duty_ramp #(
   parameter int resolution = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [resolution-1:0] target,
   input  logic [resolution-1:0] step,
   input  logic                  target_valid,
   output logic                  target_ready,
   input  logic                  period_done,
   output logic [resolution-1:0] dutyval,
   output logic                  busy,
   output logic                  settled
);

   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } state_t;

   state_t                state_r;
   state_t                state_s;
   logic [resolution-1:0] tgt_r;
   logic [resolution-1:0] tgt_s;
   logic [resolution-1:0] step_r;
   logic [resolution-1:0] step_s;
   logic [resolution-1:0] duty_s;
   logic                  busy_s;
   logic                  settled_s;
   logic [resolution:0]   diff_s;

   assign target_ready = (state_r == IDLE);

   // Distance to target, one bit wider so the magnitude never wraps
   always_comb begin
      diff_s = {(resolution+1){1'b0}};
      if (tgt_r > dutyval) begin
         diff_s = {1'b0, tgt_r} - {1'b0, dutyval};
      end else begin
         diff_s = {1'b0, dutyval} - {1'b0, tgt_r};
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_s   = state_r;
      tgt_s     = tgt_r;
      step_s    = step_r;
      duty_s    = dutyval;
      busy_s    = busy;
      settled_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (target_valid) begin
               tgt_s  = target;
               step_s = step;
               if (target == dutyval) begin
                  settled_s = 1'b1;
               end else begin
                  state_s = RAMP;
                  busy_s  = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RAMP: begin
            if (period_done) begin
               // Final step lands exactly on target; intermediate steps stay strictly short of it
               if ((step_r == {resolution{1'b0}}) || (diff_s <= {1'b0, step_r})) begin
                  duty_s    = tgt_r;
                  settled_s = 1'b1;
                  busy_s    = 1'b0;
                  state_s   = IDLE;
               end else if (tgt_r > dutyval) begin
                  duty_s = dutyval + step_r;
               end else begin
                  duty_s = dutyval - step_r;
               end
            end else begin
               state_s = RAMP;
            end
         end
         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         tgt_r   <= {resolution{1'b0}};
         step_r  <= {resolution{1'b0}};
         dutyval <= {resolution{1'b0}};
         busy    <= 1'b0;
         settled <= 1'b0;
      end else begin
         state_r <= state_s;
         tgt_r   <= tgt_s;
         step_r  <= step_s;
         dutyval <= duty_s;
         busy    <= busy_s;
         settled <= settled_s;
      end
   end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: table of ramp requests plus hand-written
// sequences for reset, held requests, equal target and coincident boundary.
module tb_pwm_duty_ramp;

   logic       clk;
   logic       reset_n;
   logic [7:0] target;
   logic [7:0] step;
   logic       target_valid;
   logic       target_ready;
   logic       period_done;
   logic [7:0] dutyval;
   logic       busy;
   logic       settled;

   int checks;
   int errors;

   typedef struct {
      logic [7:0]       target;
      logic [7:0]       step;
      int               n;
      int               spacing;
      logic [3:0][7:0]  exp;
   } vec_t;

   vec_t vecs [6];

   pwm_duty_ramp #(.resolution(8)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .target       (target),
      .step         (step),
      .target_valid (target_valid),
      .target_ready (target_ready),
      .period_done  (period_done),
      .dutyval      (dutyval),
      .busy         (busy),
      .settled      (settled)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic pulse();
      period_done = 1'b1;
      @(posedge clk);
      @(negedge clk);
      period_done = 1'b0;
   endtask

   task automatic accept(input logic [7:0] t, input logic [7:0] s);
      target       = t;
      step         = s;
      target_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      target_valid = 1'b0;
   endtask

   function automatic vec_t mk(input logic [7:0] t, input logic [7:0] s, input int n, input int sp,
                               input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
      vec_t v;
      v.target  = t;
      v.step    = s;
      v.n       = n;
      v.spacing = sp;
      v.exp     = {e3, e2, e1, e0};
      return v;
   endfunction

   initial begin
      logic [7:0] prev;
      checks       = 0;
      errors       = 0;
      reset_n      = 1'b0;
      target       = 8'd0;
      step         = 8'd0;
      target_valid = 1'b0;
      period_done  = 1'b0;

      vecs[0] = mk(8'd100, 8'd30,  4, 250, 8'd30,  8'd60, 8'd90, 8'd100);
      vecs[1] = mk(8'd10,  8'd40,  3, 5,   8'd60,  8'd20, 8'd10, 8'd0);
      vecs[2] = mk(8'd200, 8'd0,   1, 5,   8'd200, 8'd0,  8'd0,  8'd0);
      vecs[3] = mk(8'd0,   8'd0,   1, 5,   8'd0,   8'd0,  8'd0,  8'd0);
      vecs[4] = mk(8'd255, 8'd255, 1, 5,   8'd255, 8'd0,  8'd0,  8'd0);
      vecs[5] = mk(8'd0,   8'd200, 2, 5,   8'd55,  8'd0,  8'd0,  8'd0);

      // Reset state
      gap(2);
      check("rst_duty", dutyval, 8'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_settled", settled, 1'b0);
      check("rst_ready", target_ready, 1'b1);
      reset_n = 1'b1;
      gap(1);
      pulse();
      pulse();
      check("idle_pulse_duty", dutyval, 8'd0);

      // Table-driven ramps, each starting from the previous final duty
      for (int i = 0; i < 6; i++) begin
         accept(vecs[i].target, vecs[i].step);
         check($sformatf("v%0d_busy_acc", i), busy, 1'b1);
         check($sformatf("v%0d_ready_acc", i), target_ready, 1'b0);
         for (int k = 0; k < vecs[i].n; k++) begin
            prev = dutyval;
            gap(vecs[i].spacing);
            check($sformatf("v%0d_hold%0d", i, k), dutyval, prev);
            pulse();
            check($sformatf("v%0d_duty%0d", i, k), dutyval, vecs[i].exp[k]);
            if (k < vecs[i].n - 1) begin
               check($sformatf("v%0d_busy%0d", i, k), busy, 1'b1);
               check($sformatf("v%0d_settled%0d", i, k), settled, 1'b0);
            end else begin
               check($sformatf("v%0d_settled_fin", i), settled, 1'b1);
               check($sformatf("v%0d_busy_fin", i), busy, 1'b0);
               check($sformatf("v%0d_ready_fin", i), target_ready, 1'b1);
            end
         end
         gap(1);
         check($sformatf("v%0d_settled_drop", i), settled, 1'b0);
      end

      // Request held during a ramp is taken only once ready returns
      accept(8'd100, 8'd0);
      pulse();
      check("pre_down_duty", dutyval, 8'd100);
      accept(8'd10, 8'd40);
      target       = 8'd200;
      step         = 8'd100;
      target_valid = 1'b1;
      pulse();
      check("held_d1", dutyval, 8'd60);
      check("held_ready1", target_ready, 1'b0);
      pulse();
      check("held_d2", dutyval, 8'd20);
      pulse();
      check("held_d3", dutyval, 8'd10);
      check("held_ready3", target_ready, 1'b1);
      check("held_settled3", settled, 1'b1);
      @(posedge clk);
      @(negedge clk);
      target_valid = 1'b0;
      check("held_acc_busy", busy, 1'b1);
      check("held_acc_duty", dutyval, 8'd10);
      pulse();
      check("held_up1", dutyval, 8'd110);
      pulse();
      check("held_up2", dutyval, 8'd200);
      check("held_up_settled", settled, 1'b1);

      // Equal target: settled next cycle, busy never rises
      accept(8'd50, 8'd0);
      pulse();
      check("eq_pre", dutyval, 8'd50);
      gap(1);
      accept(8'd50, 8'd5);
      check("eq_settled", settled, 1'b1);
      check("eq_busy", busy, 1'b0);
      check("eq_ready", target_ready, 1'b1);
      gap(1);
      check("eq_settled_drop", settled, 1'b0);
      check("eq_busy2", busy, 1'b0);

      // Acceptance on the same edge as period_done does not move dutyval
      period_done = 1'b1;
      accept(8'd80, 8'd10);
      period_done = 1'b0;
      check("coin_duty", dutyval, 8'd50);
      check("coin_busy", busy, 1'b1);
      gap(2);
      pulse();
      check("coin_step1", dutyval, 8'd60);
      pulse();
      pulse();
      check("coin_step3", dutyval, 8'd80);
      check("coin_settled", settled, 1'b1);

      // Asynchronous reset mid-ramp
      accept(8'd0, 8'd0);
      pulse();
      accept(8'd200, 8'd20);
      pulse();
      pulse();
      pulse();
      check("mid_duty", dutyval, 8'd60);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_duty", dutyval, 8'd0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_settled", settled, 1'b0);
      check("mid_rst_ready", target_ready, 1'b1);
      @(negedge clk);
      reset_n = 1'b1;
      gap(1);
      pulse();
      check("post_rst_idle", dutyval, 8'd0);
      accept(8'd40, 8'd40);
      check("post_rst_busy", busy, 1'b1);
      pulse();
      check("post_rst_duty", dutyval, 8'd40);
      check("post_rst_settled", settled, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
